// File: rtl/seq_loop_trip_monitor.sv
// Purpose : loop trip/cycle monitor for a sequential-loop FSM, with a small record buffer.
// Latency : a record appears on rec_* one cycle after its EXIT/finish cycle when the buffer is empty.
// Backpressure: rec_valid/rec_ready handshake; a record pushed into a full buffer with no pop is dropped and flags overflow.
//
// Ports (seq_loop_trip_monitor):
//   clock, reset               sampling clock, synchronous active-high reset
//   cur_state                  current design FSM state
//   *_valid / *_state*         static loop descriptors (pre, post, quit, iteration start/end)
//   one_state_loop             an iteration consists of the start state alone
//   one_state_block            reserved, has no effect
//   finish                     simulation end; closes an open loop as incomplete
//   in_loop                    monitor FSM is in LOOP
//   rec_valid/rec_ready        record handshake
//   rec_trip/rec_cycles        head record counts (saturating)
//   rec_incomplete             head record was closed by finish
//   overflow                   sticky: a record was dropped

// Generic synchronous FIFO.
// Ports: push_vld/push_dat write side, pop_rdy read strobe, out_vld/out_dat head entry, drop = rejected push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic             drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_rdy & ~empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign do_push = push_vld & (~full | do_pop);
  assign drop    = push_vld & full & ~do_pop;

  assign out_vld = ~empty;
  assign out_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end
endmodule

module seq_loop_trip_monitor #(
  parameter int FSM_WIDTH = 2,
  parameter int CNT_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [FSM_WIDTH-1:0] cur_state,
  input  logic                 pre_states_valid,
  input  logic [FSM_WIDTH-1:0] pre_loop_state0,
  input  logic [1:0]           post_states_valid,
  input  logic [FSM_WIDTH-1:0] post_loop_state0,
  input  logic [FSM_WIDTH-1:0] post_loop_state1,
  input  logic                 quit_states_valid,
  input  logic [FSM_WIDTH-1:0] quit_loop_state0,
  input  logic [FSM_WIDTH-1:0] loop_quit_state,
  input  logic [FSM_WIDTH-1:0] iter_start_state,
  input  logic                 iter_end_states_valid,
  input  logic [FSM_WIDTH-1:0] iter_end_state0,
  input  logic                 one_state_loop,
  input  logic                 one_state_block,
  input  logic                 finish,
  output logic                 in_loop,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [CNT_WIDTH-1:0] rec_trip,
  output logic [CNT_WIDTH-1:0] rec_cycles,
  output logic                 rec_incomplete,
  output logic                 overflow
);
  localparam int REC_W = 2 * CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOOP} state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] trip_q;
  logic [CNT_WIDTH-1:0] trip_nxt;
  logic [CNT_WIDTH-1:0] cycles_q;
  logic [CNT_WIDTH-1:0] cycles_nxt;
  logic [FSM_WIDTH-1:0] prev_state;
  logic                 prev_ok;
  logic                 overflow_q;

  logic                 ev_enter;
  logic                 ev_iter;
  logic                 ev_exit;
  logic                 exit_src;
  logic                 exit_dst;

  logic                 push;
  logic [CNT_WIDTH-1:0] push_trip;
  logic [CNT_WIDTH-1:0] push_cycles;
  logic                 push_inc;
  logic [REC_W-1:0]     push_dat;
  logic [REC_W-1:0]     head_dat;
  logic                 fifo_drop;
  logic                 pop;

  // Reserved input: accepted on the port but intentionally not used.
  logic unused_one_state_block;
  assign unused_one_state_block = one_state_block;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // prev_ok keeps the first post-reset cycle from comparing against a stale prev_state.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_state <= '0;
      prev_ok    <= 1'b0;
    end else begin
      prev_state <= cur_state;
      prev_ok    <= 1'b1;
    end
  end

  // Edge events on the observed FSM, derived from the (prev_state, cur_state) pair.
  assign ev_enter = prev_ok & pre_states_valid & (prev_state == pre_loop_state0) &
                    (cur_state == iter_start_state);

  assign ev_iter  = prev_ok & (cur_state == iter_start_state) &
                    (one_state_loop ? (prev_state == iter_start_state)
                                    : (iter_end_states_valid & (prev_state == iter_end_state0)));

  assign exit_src = (prev_state == loop_quit_state) |
                    (quit_states_valid & (prev_state == quit_loop_state0));
  assign exit_dst = (post_states_valid[0] & (cur_state == post_loop_state0)) |
                    (post_states_valid[1] & (cur_state == post_loop_state1));
  assign ev_exit  = prev_ok & exit_src & exit_dst;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      trip_q   <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_nxt;
      trip_q   <= trip_nxt;
      cycles_q <= cycles_nxt;
    end
  end

  // Priority in LOOP: EXIT, then finish, then ITER.
  // The EXIT cycle itself belongs to the successor state, so it is not counted;
  // a finish cycle is still inside the loop and is counted.
  always_comb begin
    state_nxt   = state_q;
    trip_nxt    = trip_q;
    cycles_nxt  = cycles_q;
    push        = 1'b0;
    push_trip   = trip_q;
    push_cycles = cycles_q;
    push_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev_enter) begin
          state_nxt  = LOOP;
          trip_nxt   = CNT_ONE;
          cycles_nxt = CNT_ONE;
        end
      end
      LOOP: begin
        if (ev_exit) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else if (finish) begin
          push        = 1'b1;
          push_cycles = sat_inc(cycles_q);
          push_inc    = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cycles_nxt = sat_inc(cycles_q);
          if (ev_iter) begin
            trip_nxt = sat_inc(trip_q);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_loop  = (state_q == LOOP);
  assign push_dat = {push_inc, push_trip, push_cycles};
  assign pop      = rec_valid & rec_ready;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_rec_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (push),
    .push_dat (push_dat),
    .pop_rdy  (pop),
    .out_vld  (rec_valid),
    .out_dat  (head_dat),
    .drop     (fifo_drop)
  );

  assign rec_incomplete = head_dat[REC_W-1];
  assign rec_trip       = head_dat[2*CNT_WIDTH-1:CNT_WIDTH];
  assign rec_cycles     = head_dat[CNT_WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (fifo_drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
endmodule

// File: tb/tb_seq_loop_trip_monitor.sv
module tb_seq_loop_trip_monitor;
  localparam int FW = 2;

  typedef struct packed {
    logic [31:0] trip;
    logic [31:0] cycles;
    logic        inc;
  } rec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [FW-1:0] cur_a;
  logic [FW-1:0] cur_b;
  logic          pre_states_valid;
  logic [FW-1:0] pre_loop_state0;
  logic [1:0]    post_states_valid;
  logic [FW-1:0] post_loop_state0;
  logic [FW-1:0] post_loop_state1;
  logic          quit_states_valid;
  logic [FW-1:0] quit_loop_state0;
  logic [FW-1:0] loop_quit_state;
  logic [FW-1:0] iter_start_state;
  logic          iter_end_states_valid;
  logic [FW-1:0] iter_end_state0;
  logic          one_state_loop;
  logic          one_state_block;
  logic          finish_a;
  logic          finish_b;
  logic          ready_a;
  logic          ready_b;

  logic          in_loop_a, rec_valid_a, rec_inc_a, overflow_a;
  logic [31:0]   rec_trip_a, rec_cycles_a;
  logic          in_loop_b, rec_valid_b, rec_inc_b, overflow_b;
  logic [3:0]    rec_trip_b, rec_cycles_b;

  rec_t exp_a[$];
  rec_t exp_b[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  seq_loop_trip_monitor #(.FSM_WIDTH(FW), .CNT_WIDTH(32), .DEPTH(2)) dut_a (
    .clock(clock), .reset(reset), .cur_state(cur_a),
    .pre_states_valid(pre_states_valid), .pre_loop_state0(pre_loop_state0),
    .post_states_valid(post_states_valid), .post_loop_state0(post_loop_state0),
    .post_loop_state1(post_loop_state1), .quit_states_valid(quit_states_valid),
    .quit_loop_state0(quit_loop_state0), .loop_quit_state(loop_quit_state),
    .iter_start_state(iter_start_state), .iter_end_states_valid(iter_end_states_valid),
    .iter_end_state0(iter_end_state0), .one_state_loop(one_state_loop),
    .one_state_block(one_state_block), .finish(finish_a), .in_loop(in_loop_a),
    .rec_valid(rec_valid_a), .rec_ready(ready_a), .rec_trip(rec_trip_a),
    .rec_cycles(rec_cycles_a), .rec_incomplete(rec_inc_a), .overflow(overflow_a)
  );

  seq_loop_trip_monitor #(.FSM_WIDTH(FW), .CNT_WIDTH(4), .DEPTH(2)) dut_b (
    .clock(clock), .reset(reset), .cur_state(cur_b),
    .pre_states_valid(pre_states_valid), .pre_loop_state0(pre_loop_state0),
    .post_states_valid(post_states_valid), .post_loop_state0(post_loop_state0),
    .post_loop_state1(post_loop_state1), .quit_states_valid(quit_states_valid),
    .quit_loop_state0(quit_loop_state0), .loop_quit_state(loop_quit_state),
    .iter_start_state(iter_start_state), .iter_end_states_valid(iter_end_states_valid),
    .iter_end_state0(iter_end_state0), .one_state_loop(one_state_loop),
    .one_state_block(one_state_block), .finish(finish_b), .in_loop(in_loop_b),
    .rec_valid(rec_valid_b), .rec_ready(ready_b), .rec_trip(rec_trip_b),
    .rec_cycles(rec_cycles_b), .rec_incomplete(rec_inc_b), .overflow(overflow_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [FW-1:0] v);
    cur_a = v;
    tick();
  endtask

  task automatic step2(input logic [FW-1:0] v);
    cur_a = v;
    cur_b = v;
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input rec_t act, input rec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got trip=%0d cycles=%0d inc=%0d expected trip=%0d cycles=%0d inc=%0d",
               name, act.trip, act.cycles, act.inc, exp.trip, exp.cycles, exp.inc);
    end
  endtask

  task automatic set_desc_loop();
    pre_states_valid      = 1'b1;
    pre_loop_state0       = 2'd0;
    post_states_valid     = 2'b01;
    post_loop_state0      = 2'd3;
    post_loop_state1      = 2'd0;
    quit_states_valid     = 1'b0;
    quit_loop_state0      = 2'd0;
    loop_quit_state       = 2'd2;
    iter_start_state      = 2'd1;
    iter_end_states_valid = 1'b1;
    iter_end_state0       = 2'd2;
    one_state_loop        = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    cur_a           = '0;
    cur_b           = '0;
    one_state_block = 1'b0;
    finish_a        = 1'b0;
    finish_b        = 1'b0;
    ready_a         = 1'b1;
    ready_b         = 1'b1;
    set_desc_loop();

    // Monitor: pops an expected record whenever a handshake is seen and checks
    // that a stalled head record does not change.
    fork
      begin : monitor
        rec_t cur_ra, cur_rb, last_ra, last_rb;
        logic hold_a, hold_b;
        hold_a = 1'b0;
        hold_b = 1'b0;
        last_ra = '0;
        last_rb = '0;
        forever begin
          @(negedge clock);
          cur_ra = '{trip: rec_trip_a, cycles: rec_cycles_a, inc: rec_inc_a};
          cur_rb = '{trip: {28'd0, rec_trip_b}, cycles: {28'd0, rec_cycles_b}, inc: rec_inc_b};
          if (reset) begin
            hold_a = 1'b0;
            hold_b = 1'b0;
          end else begin
            if (hold_a) chk_rec("stall_hold_a", cur_ra, last_ra);
            if (hold_b) chk_rec("stall_hold_b", cur_rb, last_rb);
            if (rec_valid_a && ready_a) begin
              if (exp_a.size() == 0) chk_rec("unexpected_rec_a", cur_ra, '0);
              else chk_rec("rec_a", cur_ra, exp_a.pop_front());
            end
            if (rec_valid_b && ready_b) begin
              if (exp_b.size() == 0) chk_rec("unexpected_rec_b", cur_rb, '0);
              else chk_rec("rec_b", cur_rb, exp_b.pop_front());
            end
            hold_a  = rec_valid_a && !ready_a;
            hold_b  = rec_valid_b && !ready_b;
            last_ra = cur_ra;
            last_rb = cur_rb;
          end
        end
      end
    join_none

    tick();
    tick();
    chk("reset_in_loop", in_loop_a, 0);
    chk("reset_rec_valid", rec_valid_a, 0);
    chk("reset_rec_trip", rec_trip_a, 0);
    chk("reset_rec_cycles", rec_cycles_a, 0);
    chk("reset_rec_incomplete", rec_inc_a, 0);
    chk("reset_overflow", overflow_a, 0);
    reset = 1'b0;
    step(0);
    step(0);

    // Multi-state loop, three iterations.
    exp_a.push_back('{trip: 3, cycles: 6, inc: 1'b0});
    step(1); step(2); step(1); step(2); step(1); step(2);
    chk("t1_in_loop", in_loop_a, 1);
    step(3);
    chk("t1_latency_valid", rec_valid_a, 1);
    chk("t1_in_loop_exit", in_loop_a, 0);
    step(0);
    step(0);
    chk("t1_valid_one_cycle", rec_valid_a, 0);

    // Single-state loop.
    one_state_loop   = 1'b1;
    loop_quit_state  = 2'd1;
    post_loop_state0 = 2'd2;
    exp_a.push_back('{trip: 5, cycles: 5, inc: 1'b0});
    for (int i = 0; i < 5; i++) step(1);
    step(2);
    step(0);
    step(0);
    set_desc_loop();
    step(0);

    // finish while in LOOP.
    exp_a.push_back('{trip: 2, cycles: 4, inc: 1'b1});
    step(1); step(2); step(1);
    chk("t3_in_loop", in_loop_a, 1);
    cur_a    = 2'd2;
    finish_a = 1'b1;
    tick();
    finish_a = 1'b0;
    chk("t3_in_loop_falls", in_loop_a, 0);
    step(0);
    step(0);

    // Backpressure: three loops into a two-entry buffer.
    ready_a = 1'b0;
    exp_a.push_back('{trip: 1, cycles: 2, inc: 1'b0});
    exp_a.push_back('{trip: 2, cycles: 4, inc: 1'b0});
    step(1); step(2); step(3); step(0);
    step(1); step(2); step(1); step(2); step(3); step(0);
    chk("t4_no_overflow_yet", overflow_a, 0);
    step(1); step(2); step(1); step(2); step(1); step(2); step(3); step(0);
    chk("t4_overflow", overflow_a, 1);
    chk("t4_head_trip", rec_trip_a, 1);
    chk("t4_head_cycles", rec_cycles_a, 2);
    ready_a = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_drained_valid", rec_valid_a, 0);
    chk("t4_drained_count", exp_a.size(), 0);
    chk("t4_overflow_sticky", overflow_a, 1);

    // Reset in the middle of a loop.
    step(1); step(2); step(1);
    chk("t5_in_loop", in_loop_a, 1);
    reset = 1'b1;
    tick();
    chk("t5_reset_in_loop", in_loop_a, 0);
    chk("t5_reset_valid", rec_valid_a, 0);
    chk("t5_reset_overflow", overflow_a, 0);
    reset = 1'b0;
    step(0);
    step(0);
    exp_a.push_back('{trip: 3, cycles: 6, inc: 1'b0});
    step(1); step(2); step(1); step(2); step(1); step(2); step(3); step(0); step(0);

    // 20-cycle loop on both instances; the 4-bit counter saturates at 15.
    exp_a.push_back('{trip: 10, cycles: 20, inc: 1'b0});
    exp_b.push_back('{trip: 10, cycles: 15, inc: 1'b0});
    step2(1);
    for (int i = 0; i < 9; i++) begin
      step2(2);
      step2(1);
    end
    step2(2);
    step2(3);
    step2(0);

    for (int i = 0; i < 20; i++) begin
      if (exp_a.size() == 0 && exp_b.size() == 0) break;
      tick();
    end
    chk("final_pending_a", exp_a.size(), 0);
    chk("final_pending_b", exp_b.size(), 0);
    chk("final_overflow_b", overflow_b, 0);
    chk("final_in_loop_b", in_loop_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
